// File: rtl/elliptic_curve_structs.sv
// Shared curve-field definitions for the point arithmetic datapath.
// Provides the prime field parameters and the field element type used by
// modular_multiplier and modular_inverse.
package elliptic_curve_structs;

  localparam int PRIME_WIDTH = 256;

  typedef logic [PRIME_WIDTH-1:0] felem_t;

  // Curve constants: y^2 = x^3 + a*x + b over GF(p) (secp256k1).
  typedef struct packed {
    felem_t p;
    felem_t a;
    felem_t b;
  } curve_params_t;

  localparam curve_params_t params = '{
    p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    a: 256'd0,
    b: 256'd7
  };

endpackage

// File: rtl/mod_double_add.sv
// One MSB-first double-and-add step of a modular multiply:
//   acc_next = (2*acc + b_bit*a_r) mod p
// Requires acc < p and a_r < p. Intermediates are WIDTH+1 bits so that
// values up to 2p-1 never overflow; each reduction is one conditional
// subtract, both completed combinationally.
module mod_double_add #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH:0]   a_r,
  input  logic             b_bit,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH:0]   acc_next
);

  logic [WIDTH:0] p_ext;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;

  // Double, reduce, conditionally add a_r, reduce again.
  always_comb begin
    p_ext    = {1'b0, p};
    dbl      = acc + acc;
    dbl_red  = (dbl >= p_ext) ? dbl - p_ext : dbl;
    sum      = b_bit ? dbl_red + a_r : dbl_red;
    acc_next = (sum >= p_ext) ? sum - p_ext : sum;
  end

endmodule

// File: rtl/reg_256.sv
// Plain enabled register bank, used for wide datapath operands.
// No reset: contents are don't-care until the owning block loads them.
module reg_256 #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d whenever the owner enables a load.
  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/modular_multiplier.sv
// Bit-serial field multiplier: out = (a * b) mod params.p.
// Consumes one bit of b per clock, MSB first, with an interleaved
// double-and-add reduction; result is held on out while Done is high.
//
// Optional build macro: MODMUL_ZERO_BYPASS_EN
//   When defined, a zero multiplicand (after reduction) or zero multiplier
//   collapses the run to a single Step, so Done rises 2 edges after Start.
//
// state  | meaning
// IDLE   | waiting for Start
// LOAD   | capture reduced a, b; clear acc; preset bit counter
// STEP   | one double-and-add per cycle over b_r[cnt]
// FINISH | Done=1, out=acc; hold while Start stays high
module modular_multiplier
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH = PRIME_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] P = params.p;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_r;
  logic [WIDTH-1:0] out_r;

  logic [WIDTH:0]   p_ext;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   a_load;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   acc_next;
  logic             load_en;
  logic             acc_en;
  logic             zero_op;

  // Single conditional subtract brings any a < 2p into [0, p).
  always_comb begin
    p_ext  = {1'b0, P};
    a_ext  = {1'b0, a};
    a_load = (a_ext >= p_ext) ? a_ext - p_ext : a_ext;
  end

`ifdef MODMUL_ZERO_BYPASS_EN
  // A zero operand gives acc=0 after any number of steps, so one step
  // (cnt preset to 0) is enough.
  always_comb begin
    zero_op = (a_load == '0) || (b == '0);
  end
`else
  // Every operand runs the full WIDTH steps.
  always_comb begin
    zero_op = 1'b0;
  end
`endif

  // Operand/accumulator load strobes and accumulator next value.
  always_comb begin
    load_en = (state == LOAD);
    acc_en  = (state == LOAD) || (state == STEP);
    acc_d   = (state == LOAD) ? '0 : acc_next;
  end

  reg_256 #(.WIDTH(WIDTH + 1)) u_a_r (
    .clk (clk),
    .en  (load_en),
    .d   (a_load),
    .q   (a_r)
  );

  reg_256 #(.WIDTH(WIDTH)) u_b_r (
    .clk (clk),
    .en  (load_en),
    .d   (b),
    .q   (b_r)
  );

  reg_256 #(.WIDTH(WIDTH + 1)) u_acc (
    .clk (clk),
    .en  (acc_en),
    .d   (acc_d),
    .q   (acc)
  );

  mod_double_add #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .a_r      (a_r),
    .b_bit    (b_r[cnt]),
    .p        (P),
    .acc_next (acc_next)
  );

  // Sequencing FSM; Done and out are registered alongside the state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
      out_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) state <= LOAD;
        end
        LOAD: begin
          state <= STEP;
          cnt   <= zero_op ? '0 : CNT_INIT;
        end
        STEP: begin
          if (cnt == '0) begin
            state  <= FINISH;
            done_r <= 1'b1;
            out_r  <= acc_next[WIDTH-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          if (!Start) begin
            state  <= IDLE;
            done_r <= 1'b0;
            out_r  <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
          out_r  <= '0;
        end
      endcase
    end
  end

  assign Done = done_r;
  assign out  = out_r;

endmodule

// File: tb/tb_modular_multiplier.sv
// Scoreboard bench for modular_multiplier: stimulus pushes the expected
// product and latency; a monitor pops and compares on each rising Done.
module tb_modular_multiplier;
  import elliptic_curve_structs::*;

  localparam int     W        = PRIME_WIDTH;
  localparam felem_t P        = params.p;
  localparam int     LAT_FULL = W + 1;
`ifdef MODMUL_ZERO_BYPASS_EN
  localparam int     LAT_ZERO = 2;
`else
  localparam int     LAT_ZERO = W + 1;
`endif

  logic   clk = 1'b0;
  logic   Reset;
  logic   Start;
  felem_t a;
  felem_t b;
  felem_t out;
  logic   Done;

  int     cyc      = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  felem_t exp_q[$];
  int     lat_q[$];
  int     start_q[$];

  logic   prev_done = 1'b0;
  felem_t m_exp;
  int     m_lat;
  int     m_start;

  modular_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Start (Start),
    .a     (a),
    .b     (b),
    .out   (out),
    .Done  (Done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare on rising Done, and require out=0 whenever Done=0.
  always @(negedge clk) begin
    if (Done === 1'b1 && prev_done !== 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: Done rose with nothing pending, out=%h", out);
      end else begin
        m_exp   = exp_q.pop_front();
        m_lat   = lat_q.pop_front();
        m_start = start_q.pop_front();
        if (out !== m_exp) begin
          n_fail++;
          $display("FAIL product: got %h expected %h", out, m_exp);
        end
        n_checks++;
        if (cyc - m_start != m_lat) begin
          n_fail++;
          $display("FAIL latency: got %0d edges expected %0d", cyc - m_start, m_lat);
        end
      end
    end
    if (Done === 1'b0) begin
      n_checks++;
      if (out !== '0) begin
        n_fail++;
        $display("FAIL idle_out: out=%h while Done=0, expected 0", out);
      end
    end
    prev_done = Done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic felem_t mulmod(input felem_t x, input felem_t y);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return felem_t'(prod % {{W{1'b0}}, P});
  endfunction

  function automatic felem_t powmod(input felem_t base, input felem_t e);
    felem_t r;
    r = felem_t'(1);
    for (int i = W - 1; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, base);
    end
    return r;
  endfunction

  function automatic felem_t rand_felem();
    felem_t x;
    for (int k = 0; k < W / 32; k++) x[k*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic check(input string name, input felem_t act, input felem_t expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Called at a negedge with the DUT in Idle. Leaves at the negedge after
  // Load has captured the operands, then scrambles a/b.
  task automatic issue(input felem_t av, input felem_t bv, input felem_t ev,
                       input int lat, input bit push, input bit hold);
    a     = av;
    b     = bv;
    Start = 1'b1;
    if (push) begin
      exp_q.push_back(ev);
      lat_q.push_back(lat);
      start_q.push_back(cyc + 1);
    end
    @(negedge clk);
    if (!hold) Start = 1'b0;
    @(negedge clk);
    a = rand_felem();
    b = rand_felem();
  endtask

  // Bounded wait for Done; on return (Start low) the DUT is back in Idle.
  task automatic wait_done(input string name, input bit leave_idle);
    int k;
    k = 0;
    while (Done !== 1'b1 && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (Done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: Done not seen within 600 cycles, Done=%b expected 1", name, Done);
    end
    if (leave_idle) @(negedge clk);
  endtask

  initial begin
    felem_t x;
    felem_t inv;
    felem_t ones;
    ones  = '1;
    Reset = 1'b1;
    Start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_done", felem_t'(Done), felem_t'(0));
    check("reset_out", out, '0);
    Reset = 1'b0;
    @(negedge clk);

    issue(felem_t'(1), felem_t'(1), felem_t'(1), LAT_FULL, 1'b1, 1'b0);
    wait_done("one_one", 1'b1);
    issue(felem_t'(2), P - 1, P - 2, LAT_FULL, 1'b1, 1'b0);
    wait_done("two_pm1", 1'b1);
    issue(P - 1, P - 1, felem_t'(1), LAT_FULL, 1'b1, 1'b0);
    wait_done("pm1_sq", 1'b1);
    issue(P + 5, felem_t'(3), felem_t'(15), LAT_FULL, 1'b1, 1'b0);
    wait_done("p5_times3", 1'b1);
    issue(felem_t'(5), ones, mulmod(felem_t'(5), ones), LAT_FULL, 1'b1, 1'b0);
    wait_done("five_ones", 1'b1);
    issue(felem_t'(0), felem_t'(7), felem_t'(0), LAT_ZERO, 1'b1, 1'b0);
    wait_done("zero_a", 1'b1);
    issue(felem_t'(9), felem_t'(0), felem_t'(0), LAT_ZERO, 1'b1, 1'b0);
    wait_done("zero_b", 1'b1);

    // Inverse cross-check: x * x^(p-2) == 1.
    x   = felem_t'(16'h1234);
    inv = powmod(x, P - 2);
    issue(x, inv, felem_t'(1), LAT_FULL, 1'b1, 1'b0);
    wait_done("inv_1234", 1'b1);
    for (int i = 0; i < 4; i++) begin
      x = rand_felem();
      if (x >= P) x = x - P;
      if (x == '0) x = felem_t'(1);
      inv = powmod(x, P - 2);
      issue(x, inv, felem_t'(1), LAT_FULL, 1'b1, 1'b0);
      wait_done("inv_rand", 1'b1);
    end

    // Level handshake: Start held through Finish keeps Done and out.
    issue(felem_t'(3), felem_t'(4), felem_t'(12), LAT_FULL, 1'b1, 1'b1);
    wait_done("hold", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done", felem_t'(Done), felem_t'(1));
      check("hold_out", out, felem_t'(12));
    end
    Start = 1'b0;
    @(negedge clk);
    check("drop_done", felem_t'(Done), felem_t'(0));
    check("drop_out", out, '0);

    // Reset in the middle of Step abandons the run.
    issue(felem_t'(7), felem_t'(9), felem_t'(0), LAT_FULL, 1'b0, 1'b0);
    repeat (99) @(negedge clk);
    check("mid_done_pre", felem_t'(Done), felem_t'(0));
    Reset = 1'b1;
    @(negedge clk);
    check("mid_reset_done", felem_t'(Done), felem_t'(0));
    check("mid_reset_out", out, '0);
    Reset = 1'b0;
    issue(felem_t'(11), felem_t'(13), felem_t'(143), LAT_FULL, 1'b1, 1'b0);
    wait_done("after_reset", 1'b1);

    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
